noc_out_arbiter: RTL
====================

Name: noc_out_arbiter

Overview:
- Round-robin arbiter and output stage for one output port of noc_router.
- Sits between the three input FIFOs (East, West, Local) and one output link.
- Each cycle it selects at most one FIFO head flit addressed to this port, pops it, and registers it onto the output link.
- Respects downstream full/almost_full with the same write/full rule our writers use.

Parameters:
- WIDTH, 16, flit width in bits.
- MY_PORT, 2'b01, destination code this output serves: 00=E, 01=W, 10=L.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- emptyE  input  1  East input FIFO empty.
- emptyW  input  1  West input FIFO empty.
- emptyL  input  1  Local input FIFO empty.
- headE  input  WIDTH  East FIFO head flit (first-word-fall-through).
- headW  input  WIDTH  West FIFO head flit.
- headL  input  WIDTH  Local FIFO head flit.
- popE  output  1  pop East FIFO this cycle (combinational).
- popW  output  1  pop West FIFO this cycle (combinational).
- popL  output  1  pop Local FIFO this cycle (combinational).
- out_full  input  1  downstream FIFO full.
- out_almost_full  input  1  downstream FIFO almost full.
- dataOut  output  WIDTH  registered output flit.
- write  output  1  registered write strobe to downstream FIFO.
- last_grant  output  2  registered index of last winner: 0=E, 1=W, 2=L, 3=none.

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high, on port reset.
- Flit fields:
  - [0] valid
  - [2:1] destination port
  - [4:3] source id
  - [14:5] sequence
  - [15] reserved
  - The arbiter passes all bits through unchanged.
- Request: reqX = ~emptyX & headX[0] & (headX[2:1]==MY_PORT). Heads with a non-matching destination or valid=0 are never requested or popped.
- Stall: stall = (write & out_almost_full) | (~write & out_full). This accounts for the flit written in the previous cycle not yet being visible in out_full.
- Round-robin pointer rr (2 bits, values 0..2):
  - Index order: E=0, W=1, L=2.
  - Search order is rr, rr+1, rr+2 (mod 3). The first requester found is the winner g.
- Grant: when no stall and a winner exists:
  - popX=1 for the winner only, in the same cycle.
  - At the next edge: dataOut<=headX, write<=1, last_grant<=g, rr<=(g+1) mod 3.
- Idle or stall:
  - No pop; write<=0; dataOut holds its value; rr and last_grant hold.
- Latency: a head flit presented in cycle n appears on dataOut/write at edge n+1.
- Throughput: at most one flit per cycle.
- Pop outputs:
  - At most one of popE/popW/popL is high in any cycle.
  - Pops are forced to 0 while reset=1.
- Reset values: write=0, dataOut=0, last_grant=3, rr=0 (East has highest priority first).
- Reset mid-operation: a grant in the reset cycle is discarded (no pop). Arbitration restarts from rr=0 on the first cycle after reset is released.
- Fairness: with all three requesting continuously and no stall, the grant sequence is E,W,L,E,W,L… A requester waits at most 2 grants.
- FSM: rr is the only control state. The output register acts as a one-entry pipeline stage with no skid buffer, since a stall blocks the pop rather than the data.

Test Plan:
- Single requester: emptyE=0 with headE=16'h0023 (dest 01, valid) for 4 cycles, others empty, no stall -> popE high 4 cycles; write=1 for 4 cycles starting one edge later; dataOut=16'h0023; last_grant=0.
- Two contenders: E heads {seq k, id 00, dest 01} and L heads {seq k, id 10, dest 01}, both continuous -> grants alternate E,L,E,L; dataOut[4:3] alternates 00,10; no pop gaps.
- Three contenders plus destination filter:
  - All FIFOs non-empty with dest 01 -> order E,W,L,E.
  - Then set headW dest=10 -> W is never popped; order is E,L,E,L.
- Backpressure: continuous E traffic; raise out_almost_full while write=1 -> next cycle popE=0 and write=0. Hold out_full=1 for 3 cycles -> no pops and dataOut stable. Drop both -> popE resumes the next cycle.
- Reset mid-stream: assert reset for 1 cycle during alternating E/L grants with rr=2 -> popX=0 in the reset cycle; write=0, dataOut=0, last_grant=3 after the edge; first post-reset grant goes to E.

Source files
------------

// File: rtl/noc_out_arbiter.sv
// Round-robin arbiter and output register for one noc_router output port (E=0, W=1, L=2).
// Latency 1 cycle head->dataOut; a downstream stall blocks the pop rather than the data, so no skid buffer is needed.
module noc_out_arbiter #(
  parameter int         WIDTH   = 16,
  parameter logic [1:0] MY_PORT = 2'b01
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             emptyE,
  input  logic             emptyW,
  input  logic             emptyL,
  input  logic [WIDTH-1:0] headE,
  input  logic [WIDTH-1:0] headW,
  input  logic [WIDTH-1:0] headL,
  output logic             popE,
  output logic             popW,
  output logic             popL,
  input  logic             out_full,
  input  logic             out_almost_full,
  output logic [WIDTH-1:0] dataOut,
  output logic             write,
  output logic [1:0]       last_grant
);

  logic [1:0]       rr;
  logic [2:0]       req;
  logic             stall;
  logic             grant;
  logic [1:0]       g;
  logic [WIDTH-1:0] head_g;

  assign req[0] = ~emptyE & headE[0] & (headE[2:1] == MY_PORT);
  assign req[1] = ~emptyW & headW[0] & (headW[2:1] == MY_PORT);
  assign req[2] = ~emptyL & headL[0] & (headL[2:1] == MY_PORT);

  // Last cycle's write is not yet reflected in out_full, so judge by almost_full then.
  assign stall = write ? out_almost_full : out_full;

  always_comb begin
    g = 2'd3;
    case (rr)
      2'd0: begin
        if (req[0])      g = 2'd0;
        else if (req[1]) g = 2'd1;
        else if (req[2]) g = 2'd2;
      end
      2'd1: begin
        if (req[1])      g = 2'd1;
        else if (req[2]) g = 2'd2;
        else if (req[0]) g = 2'd0;
      end
      default: begin
        if (req[2])      g = 2'd2;
        else if (req[0]) g = 2'd0;
        else if (req[1]) g = 2'd1;
      end
    endcase
  end

  always_comb begin
    head_g = headE;
    case (g)
      2'd1:    head_g = headW;
      2'd2:    head_g = headL;
      default: head_g = headE;
    endcase
  end

  assign grant = ~reset & ~stall & (g != 2'd3);
  assign popE  = grant & (g == 2'd0);
  assign popW  = grant & (g == 2'd1);
  assign popL  = grant & (g == 2'd2);

  always_ff @(posedge clk) begin
    if (reset) begin
      write      <= 1'b0;
      dataOut    <= '0;
      last_grant <= 2'd3;
      rr         <= 2'd0;
    end else if (grant) begin
      write      <= 1'b1;
      dataOut    <= head_g;
      last_grant <= g;
      rr         <= (g == 2'd2) ? 2'd0 : g + 2'd1;
    end else begin
      write      <= 1'b0;
    end
  end

endmodule
